// File: rtl/ahb_lite_master_sequencer.sv
// AHB-Lite master sequencer: drains queued commands into pipelined SINGLE transfers.
// Optional local size/alignment rejection is enabled with AHB_SEQ_ALIGN_CHECK_EN.
module ahb_lite_master_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [CNT_W-1:0]  txn_count,
    output logic [CNT_W-1:0]  err_count
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic              a_valid_q, a_valid_d;
    logic              a_write_q, a_write_d;
    logic              a_lerr_q, a_lerr_d;
    logic [2:0]        a_size_q, a_size_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
    logic              d_valid_q, d_valid_d;
    logic              d_write_q, d_write_d;
    logic              d_lerr_q, d_lerr_d;
    logic              err_flag_q, err_flag_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]  txn_q, txn_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic              cmd_lerr, cmd_accept, advance, complete, complete_err;

`ifdef AHB_SEQ_ALIGN_CHECK_EN
    localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;
    logic [ADDR_W-1:0] align_mask;
    assign align_mask = ~({ADDR_W{1'b1}} << cmd_size);
    assign cmd_lerr   = (cmd_size > MAX_SIZE) | (|(cmd_addr & align_mask));
`else
    assign cmd_lerr = 1'b0;
`endif

    assign cmd_ready  = resetn & HREADY & ~err_flag_q & (~a_valid_q | HREADY);
    assign cmd_accept = cmd_valid & cmd_ready;
    assign advance    = HREADY & ~err_flag_q;

    always_comb begin
        a_valid_d    = a_valid_q;
        a_write_d    = a_write_q;
        a_lerr_d     = a_lerr_q;
        a_size_d     = a_size_q;
        a_addr_d     = a_addr_q;
        a_wdata_d    = a_wdata_q;
        d_valid_d    = d_valid_q;
        d_write_d    = d_write_q;
        d_lerr_d     = d_lerr_q;
        err_flag_d   = err_flag_q;
        hwdata_d     = hwdata_q;
        rsp_valid_d  = 1'b0;
        rsp_write_d  = rsp_write_q;
        rsp_error_d  = rsp_error_q;
        rsp_rdata_d  = rsp_rdata_q;
        txn_d        = txn_q;
        err_d        = err_q;
        complete     = 1'b0;
        complete_err = 1'b0;

        if (advance) begin
            complete     = d_valid_q;
            complete_err = d_lerr_q;
            d_valid_d    = a_valid_q;
            d_write_d    = a_write_q;
            d_lerr_d     = a_lerr_q;
            if (a_valid_q && a_write_q) hwdata_d = a_wdata_q;
            a_valid_d = cmd_accept;
            if (cmd_accept) begin
                a_write_d = cmd_write;
                a_lerr_d  = cmd_lerr;
                a_size_d  = cmd_size;
                a_addr_d  = cmd_addr;
                a_wdata_d = cmd_wdata;
            end
        end else if (err_flag_q) begin
            // Second error cycle: retire the faulted data phase, keep the A-stage for re-issue.
            if (HREADY) begin
                complete     = d_valid_q;
                complete_err = d_valid_q;
                d_valid_d    = 1'b0;
                err_flag_d   = 1'b0;
            end
        end else if (HRESP) begin
            err_flag_d = 1'b1;
        end

        if (complete) begin
            rsp_valid_d = 1'b1;
            rsp_write_d = d_write_q;
            rsp_error_d = complete_err;
            rsp_rdata_d = (d_write_q || d_lerr_q) ? '0 : HRDATA;
            if (txn_q != '1) txn_d = txn_q + 1'b1;
            if (complete_err && (err_q != '1)) err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_valid_q   <= 1'b0;
            a_write_q   <= 1'b0;
            a_lerr_q    <= 1'b0;
            a_size_q    <= '0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            d_lerr_q    <= 1'b0;
            err_flag_q  <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            txn_q       <= '0;
            err_q       <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_write_q   <= a_write_d;
            a_lerr_q    <= a_lerr_d;
            a_size_q    <= a_size_d;
            a_addr_q    <= a_addr_d;
            a_wdata_q   <= a_wdata_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            d_lerr_q    <= d_lerr_d;
            err_flag_q  <= err_flag_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            txn_q       <= txn_d;
            err_q       <= err_d;
        end
    end

    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = a_size_q;
    assign HTRANS    = (a_valid_q && !err_flag_q && !a_lerr_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HBURST    = 3'b000;
    assign HWDATA    = hwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rsp_rdata_q;
    assign txn_count = txn_q;
    assign err_count = err_q;
endmodule

// File: doc/ahb_lite_master_sequencer.md
Name: ahb_lite_master_sequencer

Overview:
Drains AHB-Lite transaction commands (write, size, addr, wdata) from the transaction FIFO's pop side and issues them as SINGLE transfers on the AHB-Lite master interface. Address and data phases are pipelined. The block handles HREADY wait states and the two-cycle HRESP error response, and returns one in-order response per command. It sits between the transaction queue and the bus fabric, and is the only driver of the master bus.

Parameters:
ADDR_W, 32, HADDR and cmd_addr width
DATA_W, 32, HWDATA/HRDATA width; only 32 and 64 are legal
CNT_W, 16, width of the status counters

Ports:
clk  input  1  bus clock; all logic on its rising edge
resetn  input  1  asynchronous, active-low reset
cmd_valid  input  1  a command is available at the FIFO head
cmd_ready  output  1  command accepted on a clk edge where cmd_valid and cmd_ready are both 1
cmd_write  input  1  1 = write, 0 = read
cmd_size  input  3  HSIZE encoding
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data (ignored for reads)
HADDR  output  ADDR_W  address-phase address
HWRITE  output  1  address-phase direction
HSIZE  output  3  address-phase size
HTRANS  output  2  IDLE=2'b00, NONSEQ=2'b10; no other values are ever driven
HBURST  output  3  constant 3'b000 (SINGLE)
HWDATA  output  DATA_W  data-phase write data
HREADY  input  1  transfer-complete / wait-state indication
HRESP  input  1  0 = OKAY, 1 = ERROR
HRDATA  input  DATA_W  read data
rsp_valid  output  1  one-cycle pulse per completed command
rsp_write  output  1  direction of the completed command
rsp_rdata  output  DATA_W  captured HRDATA; 0 for writes
rsp_error  output  1  completed with ERROR
txn_count  output  CNT_W  completed commands; saturates at all-ones
err_count  output  CNT_W  commands completed with error; saturates at all-ones

Behaviour:
- Two internal stages:
  - A-stage: the command in its address phase.
  - D-stage: the command in its data phase.
  - Each stage has a valid bit.
- Reset (asynchronous, while resetn=0):
  - Both stages invalid, error flag clear, counters 0.
  - HTRANS=IDLE; HADDR, HSIZE, HWRITE, HWDATA=0.
  - rsp_valid, rsp_write, rsp_rdata, rsp_error=0; cmd_ready=0.
  - Commands in flight when reset asserts are dropped with no response.
- Bus drive from the A-stage:
  - HADDR, HWRITE, HSIZE, HTRANS come from registered A-stage fields.
  - HTRANS=NONSEQ when the A-stage is valid and the error flag is clear; otherwise IDLE.
- HWDATA = D-stage wdata while the D-stage holds a write; otherwise it holds its last value.
- cmd_ready = HREADY & ~err_flag & (~A_valid | HREADY). This is combinational from HREADY.
- On each edge with HREADY=1 and err_flag=0:
  - The D-stage completes if valid.
  - The A-stage moves into the D-stage.
  - An accepted command loads the A-stage; if none is accepted, the A-stage becomes invalid.
- Zero-bubble throughput: a command issued in cycle N has its data phase in cycle N+1 when HREADY=1.
- HREADY=0, HRESP=0 (wait state): all stages and bus outputs hold.
- Error, first cycle (edge sampling HREADY=0, HRESP=1):
  - Set err_flag.
  - The next cycle drives HTRANS=IDLE. The pending A-stage command is cancelled on the bus but retained internally.
- Error, second cycle (edge sampling HREADY=1 with err_flag=1):
  - The D-stage completes with rsp_error=1.
  - Clear err_flag.
  - The A-stage stays in the A-stage and is re-driven as NONSEQ on the following cycle.
  - No new command is accepted on this edge.
- Completion:
  - rsp_valid pulses in the cycle after the completing edge.
  - rsp_rdata = HRDATA sampled at that edge for reads; 0 for writes.
  - Responses are in command order. There is no response backpressure.
- Counters:
  - txn_count increments on every completion.
  - err_count increments on completions with error.
  - Both saturate at 2^CNT_W-1.

Optional Feature:
Macro AHB_SEQ_ALIGN_CHECK_EN.
- With the macro defined, an accepted command is flagged local_err if either:
  - cmd_size > log2(DATA_W/8), or
  - cmd_addr is not aligned to 2^cmd_size.
- A local_err command:
  - occupies its A-stage slot with HTRANS=IDLE, so it never appears on the bus;
  - moves to the D-stage on the next HREADY edge and completes there with rsp_error=1 and rsp_rdata=0;
  - is counted in err_count;
  - keeps response order intact.
- Without the macro, every command is issued unchecked.

Test Plan:
- Reset mid-transfer: assert resetn=0 during a wait state -> HTRANS=00 asynchronously, counters 0, no rsp_valid afterwards.
- Back-to-back: three commands (W 0x100 data 0xA5A5A5A5; R 0x104; W 0x108), HREADY=1 -> NONSEQ in 3 consecutive cycles, HWDATA=0xA5A5A5A5 one cycle after the first, 3 rsp pulses in order, txn_count=3.
- Wait states: read 0x200 with HREADY=0 for 2 cycles, then 1 with HRDATA=0xDEADBEEF -> HADDR held 3 cycles, cmd_ready=0 during the wait, rsp_rdata=0xDEADBEEF.
- Error response: write 0x300, then a queued read 0x304; slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS=IDLE in the second error cycle, rsp_error=1 for 0x300, 0x304 re-driven NONSEQ the next cycle and completing OKAY, err_count=1.
- Saturation: CNT_W=2, issue 5 commands -> txn_count stops at 3.
- AHB_SEQ_ALIGN_CHECK_EN: word read at 0x102 -> never driven on the bus, rsp_error=1; without the macro it is driven with HADDR=0x102.
